axi_lite_master: RTL

- Single-outstanding AXI4-Lite initiator that converts a simple command/response interface into AXI4-Lite read and write transactions.
- It drives the distributed-RAM test memory and any other AXI4-Lite responder on the same bus.
- Its port naming and widths match the responder side: the m_axi_* signals connect one-to-one to the responder's s_axi_*.

---
 rtl/axi_lite_pkg.sv | 23 ++
 rtl/axi_lite_timeout.sv | 27 ++
 rtl/axi_lite_master.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the command-to-AXI initiator: response codes,
// master FSM states and the default protection value.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RESP
  } master_state_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_timeout.sv
// Wait-state watchdog: counts held cycles and flags when CYCLES-1 is reached.
// Instantiated by axi_lite_master only when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module axi_lite_timeout #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == W'(CYCLES - 1));

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a command/response port.
// Optional watchdog: define AXI_LITE_MASTER_TIMEOUT_EN.
//   state          | meaning
//   S_IDLE         | cmd_ready, latch command
//   S_RD_ADDR      | arvalid until arready
//   S_RD_DATA      | rready until rvalid, capture rdata/rresp
//   S_WR_ADDR_DATA | awvalid/wvalid, each drops after its own handshake
//   S_WR_RESP      | bready until bvalid
//   S_RESP         | rsp_valid until rsp_ready
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 13,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [2:0] AXI_PROT       = AXI_PROT_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [2:0]            m_axi_awprot,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [2:0]            m_axi_arprot,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  master_state_e         r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [3:0]            r_wstrb;
  logic                  r_aw_done, r_w_done, r_err;
  logic                  w_aw_hs, w_w_hs, w_wr_done;
  logic                  w_in_wait, w_expired, w_timeout, w_unused;

  assign cmd_ready     = (r_state == S_IDLE);
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_rdata     = r_rdata;
  assign rsp_err       = r_err;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arvalid = (r_state == S_RD_ADDR);
  assign m_axi_rready  = (r_state == S_RD_DATA);
  assign m_axi_bready  = (r_state == S_WR_RESP);
  assign m_axi_awvalid = (r_state == S_WR_ADDR_DATA) && !r_aw_done;
  assign m_axi_wvalid  = (r_state == S_WR_ADDR_DATA) && !r_w_done;

  assign w_aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_w_hs    = m_axi_wvalid && m_axi_wready;
  assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_in_wait = (r_state != S_IDLE) && (r_state != S_RESP);
  assign w_timeout = w_in_wait && w_expired;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic w_tmo_clear;
  // Clearing on any state change zeroes the count for the first cycle of each wait state.
  assign w_tmo_clear = (w_next != r_state);

  axi_lite_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tmo_clear),
    .i_enable  (w_in_wait),
    .o_expired (w_expired)
  );
  assign w_unused = m_axi_rresp[0] ^ m_axi_bresp[0];
`else
  assign w_expired = 1'b0;
  assign w_unused  = m_axi_rresp[0] ^ m_axi_bresp[0] ^ (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:         if (cmd_valid) w_next = cmd_write ? S_WR_ADDR_DATA : S_RD_ADDR;
      S_RD_ADDR:      if (w_timeout) w_next = S_RESP;
                      else if (m_axi_arready) w_next = S_RD_DATA;
      S_RD_DATA:      if (w_timeout || m_axi_rvalid) w_next = S_RESP;
      S_WR_ADDR_DATA: if (w_timeout) w_next = S_RESP;
                      else if (w_wr_done) w_next = S_WR_RESP;
      S_WR_RESP:      if (w_timeout || m_axi_bvalid) w_next = S_RESP;
      S_RESP:         if (rsp_ready) w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_timeout) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_addr    <= cmd_addr;
          r_wdata   <= cmd_wdata;
          r_wstrb   <= cmd_wstrb;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        S_RD_DATA: if (m_axi_rvalid) begin
          r_rdata <= m_axi_rdata;
          r_err   <= m_axi_rresp[1];
        end
        S_WR_ADDR_DATA: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        S_WR_RESP: if (m_axi_bvalid) begin
          r_rdata <= '0;
          r_err   <= m_axi_bresp[1];
        end
        default: ;
      endcase
    end
  end

endmodule
